// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO that sits directly in front of the UART transmitter. The system
// side pushes bytes with a valid/ready handshake. The head entry is presented
// first-word-fall-through on tx_valid/tx_data, and the UART pops it with
// tx_ready.
//
// Parameters
//   DATA_W      byte width (must match the UART data input)
//   DEPTH_LOG2  log2 of the entry count, 1..8
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   wr_valid/wr_data  upstream byte; wr_ready = !full
//   tx_valid/tx_data  head entry towards the UART; tx_ready pops it
//   flush             synchronous clear of all entries (overflow untouched)
//   count/empty/full  occupancy, derived from the registered pointers
//   overflow/ovf_clr  sticky write-while-full flag and its clear
//
// Build option
//   UART_TX_FIFO_OVERFLOW_EN  when defined, overflow is a sticky flag.
//                             Otherwise overflow is tied low and ovf_clr
//                             is ignored.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  tx_valid,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // The pointers carry one extra MSB as a wrap flag. Their difference
  // modulo 2^(DEPTH_LOG2+1) is the occupancy, so full and empty can be
  // told apart without any special case at the end of the array.
  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0] rd_ptr_reg, rd_ptr_next;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   entry_q [DEPTH];

  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign wr_ready = !full;
  assign tx_valid = !empty;

  // Writes are gated on !full, so the slot under rd_ptr is never rewritten
  // while it is being presented. Flush overrides both sides.
  assign wr_en = wr_valid && wr_ready && !flush;
  assign rd_en = tx_valid && tx_ready && !flush;

  // Storage: one register per entry with a decoded write enable. The entries
  // have no reset because their contents are meaningless once the pointers
  // are cleared.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg[DEPTH_LOG2-1:0] == DEPTH_LOG2'(gi))) begin
          entry_reg <= wr_data;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // First-word-fall-through: the head entry is read combinationally.
  assign tx_data = entry_q[rd_ptr_reg[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  // A write attempted while full is dropped and latches the flag. If a set
  // and a clear happen in the same cycle, the set wins.
  logic overflow_reg, overflow_next;

  always_comb begin
    overflow_next = overflow_reg;
    if (wr_valid && full) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= overflow_next;
    end
  end

  assign overflow = overflow_reg;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. The reference model is a queue of bytes with
// occupancy rules, plus a sticky overflow bit when the option is enabled.
module tb_uart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_valid = 1'b0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                wr_ready;
  logic                tx_valid;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_ready = 1'b0;
  logic                flush = 1'b0;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                overflow;
  logic                ovf_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] model_q[$];
  logic              ovf_m = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .flush(flush), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = model_q.size();
    chk({tag, ":count"},    32'(count),    32'(n));
    chk({tag, ":empty"},    32'(empty),    32'(n == 0));
    chk({tag, ":full"},     32'(full),     32'(n == DEPTH));
    chk({tag, ":wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
    chk({tag, ":tx_valid"}, 32'(tx_valid), 32'(n != 0));
    if (n != 0) chk({tag, ":tx_data"}, 32'(tx_data), 32'(model_q[0]));
    chk({tag, ":overflow"}, 32'(overflow), 32'(ovf_m));
  endtask

  // Applies one cycle of inputs, advances the model across the clock edge,
  // then checks every output 1 time unit after the edge.
  task automatic step(input string tag, input logic wv, input logic [DATA_W-1:0] wd,
                      input logic tr, input logic fl, input logic oc);
    bit full_m, do_w, do_r, ovf_set;
    wr_valid = wv; wr_data = wd; tx_ready = tr; flush = fl; ovf_clr = oc;
    full_m  = (model_q.size() == DEPTH);
    do_w    = wv && !full_m;
    do_r    = tr && (model_q.size() != 0);
    ovf_set = wv && full_m;
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc=%0d %s wv=%0d wd=%02h tr=%0d fl=%0d oc=%0d -> count=%0d tx_valid=%0d tx_data=%02h ovf=%0d",
             cyc, tag, wv, wd, tr, fl, oc, count, tx_valid, tx_data, overflow);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_r) void'(model_q.pop_front());
      if (do_w) model_q.push_back(wd);
    end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    if (ovf_set) ovf_m = 1'b1;
    else if (oc) ovf_m = 1'b0;
`else
    if (ovf_set || oc) ovf_m = 1'b0;
`endif
    check_all(tag);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    // Single byte held at the head while the UART is busy
    step("wr_c1", 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    chk("c1_head", 32'(tx_data), 32'h0C1);
    for (int i = 0; i < 3; i++) step("hold_c1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill to full with 0x01..0x10
    step("flush0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'(DEPTH));

    // Writes while full are dropped; a read in the same cycle still does
    // not open the slot for this write
    step("wr_ff_full", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("wr_ff_full", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("wr_ff_rd", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Drain in order, then clear the overflow flag
    while (model_q.size() != 0) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained_empty", 32'(empty), 32'd1);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Continuous write and read across the pointer wrap
    for (int i = 0; i < 3; i++) step("prefill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", 32'(count), 32'd3);

    // Flush together with a write at count=5
    step("flush1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step("flush_wr", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_tx_valid", 32'(tx_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-burst
    step("flush2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("burst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    model_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("post_rst");
    step("wr_0b", 1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    chk("first_after_rst", 32'(tx_data), 32'h00B);
    step("rd_0b", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
